// File: rtl/rom_loader_if.sv
// Byte-stream / memory-write bundle for the ROM loader.
// The slave side is the loader itself. The master side is the byte source and
// the memory/CPU observer.
interface rom_loader_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_write_enable;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_address, mem_data_out, mem_write_enable,
        output busy, done, error
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_address, mem_data_out, mem_write_enable,
        input  busy, done, error
    );
endinterface

// File: rtl/rom_loader.sv
// Framed byte-stream loader for the 2048x8 program RAM.
// Frame: SYNC, addr_lo, addr_hi, len_lo, len_hi, len data bytes, checksum.
// Each data byte takes a DATA cycle followed by a one-cycle WRITE strobe.
// The CPU is held halted through busy while a frame is in progress.
module rom_loader #(
    parameter int         ADDR_WIDTH = 11,
    parameter int         DATA_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    rom_loader_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_LO,
        S_ADDR_HI,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECKSUM,
        S_DONE
    } state_t;

    state_t                state, state_next;
    logic                  accept;
    logic                  len_zero;
    logic [15:0]           addr_wide;
    logic [15:0]           count;
    logic [DATA_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ready_q;
    logic                  we_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    // Checksum accumulation: plain 8-bit sum, wrapping mod 256.
    function automatic logic [DATA_WIDTH-1:0] sum_add(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] val
    );
        return acc + val;
    endfunction

    assign accept    = bus.rx_valid && ready_q;
    assign len_zero  = ({bus.rx_data, count[7:0]} == 16'd0);
    // The high address byte is merged with the already-latched low byte.
    // Bits at or above ADDR_WIDTH are dropped by the slice at the point of use.
    assign addr_wide = (state == S_ADDR_HI) ? {bus.rx_data, addr_q[7:0]}
                                            : {8'h00, bus.rx_data};

    assign bus.rx_ready         = ready_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_data_out     = data_q;
    assign bus.mem_write_enable = we_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.error            = error_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic: byte-consuming states advance only on an accepted byte.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (accept && bus.rx_data == SYNC_BYTE) state_next = S_ADDR_LO;
            S_ADDR_LO:  if (accept) state_next = S_ADDR_HI;
            S_ADDR_HI:  if (accept) state_next = S_LEN_LO;
            S_LEN_LO:   if (accept) state_next = S_LEN_HI;
            S_LEN_HI:   if (accept) state_next = len_zero ? S_CHECKSUM : S_DATA;
            S_DATA:     if (accept) state_next = S_WRITE;
            S_WRITE:    state_next = (count == 16'd1) ? S_CHECKSUM : S_DATA;
            S_CHECKSUM: if (accept) state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= !(state_next == S_WRITE || state_next == S_DONE);
            we_q    <= (state_next == S_WRITE);
            busy_q  <= (state_next != S_IDLE);
            done_q  <= (state_next == S_DONE);
        end
    end

    // Address, data, length and checksum bookkeeping.
    // error is sticky until the next sync byte is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            count   <= '0;
            sum     <= '0;
            error_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && bus.rx_data == SYNC_BYTE) begin
                        sum     <= '0;
                        error_q <= 1'b0;
                    end
                end
                S_ADDR_LO, S_ADDR_HI: begin
                    if (accept) addr_q <= addr_wide[ADDR_WIDTH-1:0];
                end
                S_LEN_LO: begin
                    if (accept) count[7:0] <= bus.rx_data;
                end
                S_LEN_HI: begin
                    if (accept) count[15:8] <= bus.rx_data;
                end
                S_DATA: begin
                    if (accept) begin
                        data_q <= bus.rx_data;
                        sum    <= sum_add(sum, bus.rx_data);
                    end
                end
                S_WRITE: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    count  <= count - 16'd1;
                end
                S_CHECKSUM: begin
                    if (accept && bus.rx_data != sum) error_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader.
// Each frame's expected memory writes and done/error outcome are derived from
// the frame contents alone and queued before the frame is streamed in.
// A monitor process checks every strobe and every done pulse against the queues.
module tb_rom_loader;
    localparam int AW = 11;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rom_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) bus ();

    rom_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wr_t        wr_q[$];
    bit         done_q[$];
    logic [7:0] pl[$];
    int         checks = 0;
    int         errors = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every strobe and done pulse must match the scoreboard head.
    initial begin : monitor
        bit prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_write_enable === 1'b1) begin : mon_wr
                wr_t e;
                check("write_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    check("write_addr", 32'(bus.mem_address), 32'(e.addr));
                    check("write_data", 32'(bus.mem_data_out), 32'(e.data));
                end
                check("ready_low_in_write", 32'(bus.rx_ready), 32'd0);
            end
            if (bus.done === 1'b1) begin : mon_done
                bit e;
                check("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
                    check("done_error", 32'(bus.error), 32'(e));
                    check("done_busy", 32'(bus.busy), 32'd1);
                end
                check("done_one_cycle", 32'(prev_done), 32'd0);
            end
            prev_done = bus.done;
        end
    end

    // Present one byte, hold it until it is taken, then drop valid.
    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int n;
        if (gappy) repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("handshake_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    // Reference model plus stimulus for one frame carrying payload pl.
    // stop_after >= 0 streams only that many data bytes (aborted frame).
    task automatic send_frame(input logic [15:0] addr, input bit bad,
                              input bit gappy, input int stop_after);
        logic [7:0] s;
        int         len;
        wr_t        w;
        len = pl.size();
        s   = 8'h00;
        for (int i = 0; i < len; i++) begin
            s = 8'((int'(s) + int'(pl[i])) % 256);
            if (stop_after < 0 || i < stop_after) begin
                w.addr = AW'((int'(addr) + i) % 2048);
                w.data = pl[i];
                wr_q.push_back(w);
            end
        end
        if (stop_after < 0) done_q.push_back(bad);
        send_byte(8'hA5, gappy);
        send_byte(addr[7:0], gappy);
        send_byte(addr[15:8], gappy);
        send_byte(8'(len % 256), gappy);
        send_byte(8'(len / 256), gappy);
        for (int i = 0; i < len; i++) begin
            if (stop_after >= 0 && i >= stop_after) return;
            send_byte(pl[i], gappy);
        end
        send_byte(bad ? ~s : s, gappy);
    endtask

    // Wait for the scoreboard to drain, then check the idle outputs.
    task automatic wait_idle(input bit exp_err);
        int n;
        n = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("drain_timeout", 32'(n), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_error", 32'(bus.error), 32'(exp_err));
        check("idle_ready", 32'(bus.rx_ready), 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_we", 32'(bus.mem_write_enable), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_data", 32'(bus.mem_data_out), 32'd0);
    endtask

    initial begin : main
        bit bad;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b1;
        @(negedge clk);

        // Basic load.
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h0100, 1'b0, 1'b0, -1);
        wait_idle(1'b0);

        // Zero length: no strobes, done still pulses.
        pl = '{};
        send_frame(16'h0010, 1'b0, 1'b0, -1);
        wait_idle(1'b0);

        // Bad checksum: byte still written, error sticks.
        pl = '{8'h7F};
        send_frame(16'h0000, 1'b1, 1'b0, -1);
        wait_idle(1'b1);

        // Following good frame clears error at its sync.
        pl = '{8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(16'h0123, 1'b0, 1'b0, -1);
        wait_idle(1'b0);

        // Junk before the frame, then a frame with random valid gaps.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        pl = '{};
        for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
        send_frame(16'h0345, 1'b0, 1'b1, -1);
        wait_idle(1'b0);

        // Sync value inside the payload is plain data.
        pl = '{8'hA5, 8'hA5, 8'h00};
        send_frame(16'h0400, 1'b0, 1'b0, -1);
        wait_idle(1'b0);

        // Address wrap from 0x7FF to 0x000.
        pl = '{8'hAA, 8'hBB};
        send_frame(16'h07FF, 1'b0, 1'b0, -1);
        wait_idle(1'b0);

        // Reset mid-frame after 2 of 4 data bytes.
        pl = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(16'h0200, 1'b0, 1'b0, 2);
        begin : drain_partial
            int n;
            n = 0;
            while (wr_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("partial_timeout", 32'(n), 32'd0);
        end
        @(negedge clk);
        check("busy_midframe", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // A full frame after the aborted one.
        pl = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(16'h0200, 1'b0, 1'b0, -1);
        wait_idle(1'b0);

        // Random frames: random length, full 16-bit address, random faults and gaps.
        for (int f = 0; f < 15; f++) begin
            int len;
            len = $urandom_range(0, 12);
            pl  = '{};
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            bad = ($urandom_range(0, 3) == 0);
            send_frame(16'($urandom), bad, 1'($urandom_range(0, 1)), -1);
            wait_idle(bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Byte-stream memory writer; the write-side counterpart to the 2048x8 program memory read path.
- Accepts framed bytes from a receiver (typically the UART RX) over a valid/ready handshake.
- Writes the payload into the 2048-byte program RAM and holds the CPU halted while loading.
- Frame format: sync 0xA5, addr_lo, addr_hi, len_lo, len_hi, len data bytes, checksum (8-bit sum of data bytes, mod 256).

Parameters:
- ADDR_WIDTH, 11, memory address width (2048 entries).
- DATA_WIDTH, 8, memory data width; must equal the stream byte width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, asynchronous active-low reset.
- rx_data, input, 8, incoming stream byte.
- rx_valid, input, 1, rx_data is valid.
- rx_ready, output, 1, loader can accept a byte.
- mem_address, output, ADDR_WIDTH, write address.
- mem_data_out, output, DATA_WIDTH, write data.
- mem_write_enable, output, 1, one-cycle write strobe.
- busy, output, 1, a frame is in progress; drives the CPU halt.
- done, output, 1, one-cycle pulse when a frame completes.
- error, output, 1, checksum mismatch on the last frame; sticky.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - rx_ready=1; mem_write_enable=0, busy=0, done=0, error=0.
  - mem_address=0, mem_data_out=0; internal count and sum cleared.
- Byte acceptance: a byte is accepted on a rising edge where rx_valid=1 and rx_ready=1. No other byte is consumed.
- rx_ready is registered as a function of state only: 1 in IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA and CHECKSUM; 0 in WRITE and DONE.
- IDLE:
  - Accepted byte equal to SYNC_BYTE -> ADDR_LO, busy=1, error=0, sum=0.
  - Any other byte is discarded; state stays IDLE.
- ADDR_LO / ADDR_HI:
  - Accepted byte is latched into address bits [7:0] / [15:8].
  - Bits at or above ADDR_WIDTH are dropped.
- LEN_LO / LEN_HI:
  - Accepted byte is latched into the 16-bit count.
  - After LEN_HI: count==0 -> CHECKSUM; otherwise -> DATA.
- DATA: accepted byte is latched into mem_data_out, added to sum (mod 256), then -> WRITE.
- WRITE (exactly 1 cycle):
  - mem_write_enable=1 with stable mem_address and mem_data_out.
  - Next edge: address increments modulo 2^ADDR_WIDTH (0x7FF wraps to 0x000), count decrements.
  - If the new count is 0 -> CHECKSUM, else -> DATA.
- CHECKSUM:
  - Accepted byte is compared with sum; on mismatch error=1.
  - -> DONE in all cases.
  - Bytes already written are not rolled back.
- DONE (1 cycle): done=1, busy stays 1; next edge -> IDLE with busy=0.
- Throughput: at most one data byte per 2 cycles (DATA+WRITE). The upstream must hold rx_valid/rx_data until rx_ready is seen.
- mem_write_enable is never asserted outside WRITE. Exactly len strobes are issued per frame.
- error holds until the next accepted SYNC_BYTE or reset.
- A SYNC_BYTE value received inside a frame is treated as data, with no resynchronisation.
- Reset mid-frame aborts immediately: partial writes remain in memory, busy drops asynchronously, and no done pulse is produced.
- Width rules: count is 16 bits, but a frame with len > 2^ADDR_WIDTH simply wraps and overwrites.

Test Plan:
- Basic load: stream A5 00 01 03 00 11 22 33 66 -> three strobes writing 0x100=11, 0x101=22, 0x102=33; done pulse 1 cycle; error=0; busy=0 afterwards.
- Zero length: A5 10 00 00 00 00 -> no mem_write_enable; done pulses; error=0.
- Bad checksum: A5 00 00 01 00 7F 00 -> 0x000=7F written, done pulses, error=1. A following good frame's sync clears error.
- Junk and backpressure: 00 FF 5A, then a valid frame with random rx_valid gaps -> junk ignored; each byte consumed once; rx_ready=0 in every WRITE cycle; writes match the payload.
- Wrap: A5 FF 07 02 00 AA BB 65 -> 0x7FF=AA, then 0x000=BB; error=0.
- Reset mid-frame: assert reset after 2 of 4 data bytes -> outputs go to reset values asynchronously. A subsequent full frame loads correctly.
